cfg_loader: RTL and testbench
=============================

CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter: cntWidth, default 16, width of the per-neuron weight counter; maximum weights per neuron is 2^cntWidth-1.
REQ-002 Parameter: endMarker, default 32'hFFFF_FFFF, layer-header value that terminates a load.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-low.
REQ-005 Port: start  input  1  one-cycle pulse that arms a new load.
REQ-006 Port: s_data  input  32  configuration stream word.
REQ-007 Port: s_valid  input  1  s_data is valid.
REQ-008 Port: s_ready  output  1  loader accepts s_data this cycle.
REQ-009 Port: weightValid  output  1  weightValue is valid for the addressed neuron.
REQ-010 Port: biasValid  output  1  biasValue is valid for the addressed neuron.
REQ-011 Port: weightValue  output  32  weight word to the neuron array.
REQ-012 Port: biasValue  output  32  bias word to the neuron array.
REQ-013 Port: config_layer_num  output  32  target layer of the current record.
REQ-014 Port: config_neuron_num  output  32  target neuron of the current record.
REQ-015 Port: busy  output  1  high from accepted start until load_done.
REQ-016 Port: load_done  output  1  one-cycle pulse when the end marker is accepted.
REQ-017 Port: record_cnt  output  16  number of complete records delivered since start.

Function
REQ-018 A transfer occurs on a rising edge where s_valid and s_ready are both high.
REQ-019 Record format: word0 layer, word1 neuron, word2 weight count N, then N weight words, then one bias word.
REQ-020 FSM states: IDLE, HDR_LAYER, HDR_NEURON, HDR_COUNT, WEIGHTS, BIAS.
REQ-021 IDLE: s_ready=0; start -> HDR_LAYER and busy=1 on the next cycle.
REQ-022 HDR_LAYER: transfer of endMarker -> IDLE with a load_done pulse on the next cycle; any other value is stored in config_layer_num -> HDR_NEURON.
REQ-023 HDR_NEURON: transfer stored in config_neuron_num -> HDR_COUNT.
REQ-024 HDR_COUNT: transfer loads the counter with s_data[cntWidth-1:0]; N=0 -> BIAS, else -> WEIGHTS.
REQ-025 WEIGHTS: each transfer decrements the counter; the transfer taking it to 0 -> BIAS.
REQ-026 BIAS: transfer -> HDR_LAYER and record_cnt increments by 1.
REQ-027 s_ready = 1 in every state except IDLE; no backpressure exists on the neuron side.
REQ-028 Latency: weightValid/biasValid assert exactly 1 cycle after the corresponding transfer, for exactly 1 cycle, with weightValue/biasValue registered on the same edge.
REQ-029 config_layer_num/config_neuron_num change only on header transfers and stay stable through the whole weight and bias phase and after it.
REQ-030 Weights in a record are emitted in stream order, so neuron write addresses increment 0..N-1.
REQ-031 s_valid low stalls the FSM with no output pulse; gaps of any length are legal.
REQ-032 start while busy is ignored; start in the same cycle that load_done is issued is ignored.
REQ-033 The accepted start clears record_cnt to 0; record_cnt saturates at 16'hFFFF.
REQ-034 weightValid and biasValid are never high in the same cycle.

Reset
REQ-035 rst low asynchronously forces IDLE, with s_ready, busy, load_done, weightValid, biasValid, record_cnt, counter, weightValue, biasValue, config_layer_num and config_neuron_num all 0.
REQ-036 rst asserted mid-record abandons the record with no further output pulses; a new start is required after release.

Structure
REQ-037 A shared package holds the FSM state enum, the default endMarker constant and the record word offsets (LAYER=0, NEURON=1, COUNT=2).
REQ-038 The block is a single module with no sub-modules; the counter and FSM live in the same module.

Verification
REQ-039 start, then stream {2,4,3,W0,W1,W2,B} with s_valid held high -> three weightValid pulses with values W0..W2 on consecutive cycles, layer=2, neuron=4, then biasValid with B, record_cnt=1.
REQ-040 Record {1,0,0,B} -> no weightValid, one biasValid 1 cycle after the B transfer, record_cnt=1.
REQ-041 Two records followed by 32'hFFFF_FFFF, with s_valid toggling randomly -> pulses match the stream order, load_done pulses once, busy falls, s_ready=0, record_cnt=2.
REQ-042 rst asserted after the second weight of N=5 -> all outputs 0 immediately; after release, stream words with no start are not accepted (s_ready=0).
REQ-043 start pulsed while busy, and s_valid raised in IDLE -> no state change, no transfer, record_cnt unchanged.

Source files
------------

// File: rtl/cfg_loader_pkg.sv
// -----------------------------------------------------------------------------
// cfg_loader_pkg
// Shared definitions for the configuration-stream loader:
//   - state_t      : FSM state encoding
//   - word_ofs_t   : position of each header word inside a record
//   - DEFAULT_END_MARKER : layer-header value that terminates a load
// -----------------------------------------------------------------------------
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HDR_LAYER  = 3'd1,
    HDR_NEURON = 3'd2,
    HDR_COUNT  = 3'd3,
    WEIGHTS    = 3'd4,
    BIAS       = 3'd5
  } state_t;

  // Header word positions within one record; the weights follow COUNT and
  // the single bias word closes the record.
  typedef enum logic [1:0] {
    OFS_LAYER  = 2'd0,
    OFS_NEURON = 2'd1,
    OFS_COUNT  = 2'd2
  } word_ofs_t;

  localparam logic [31:0] DEFAULT_END_MARKER = 32'hFFFF_FFFF;

endpackage : cfg_loader_pkg

// File: rtl/cfg_loader.sv
// -----------------------------------------------------------------------------
// cfg_loader
// Parses a valid/ready configuration stream into per-neuron weight and bias
// writes. Record = layer, neuron, weight count N, N weights, one bias.
// A layer header equal to endMarker finishes the load.
//
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   start                : one-cycle pulse that arms a load (ignored when busy)
//   s_data/s_valid       : input stream; s_ready is high in every non-IDLE state
//   weightValid/Value    : one-cycle weight write, 1 cycle after its transfer
//   biasValid/Value      : one-cycle bias write, 1 cycle after its transfer
//   config_layer_num     : layer of the current record (held after the record)
//   config_neuron_num    : neuron of the current record (held after the record)
//   busy                 : high from accepted start until load_done
//   load_done            : one-cycle pulse after the end marker is accepted
//   record_cnt           : complete records since start, saturating
// -----------------------------------------------------------------------------
module cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int          cntWidth  = 16,
  parameter logic [31:0] endMarker = DEFAULT_END_MARKER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic        biasValid,
  output logic [31:0] weightValue,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        load_done,
  output logic [15:0] record_cnt
);

  localparam logic [cntWidth-1:0] CNT_ZERO = {cntWidth{1'b0}};
  localparam logic [cntWidth-1:0] CNT_ONE  = {{(cntWidth-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              next_state;
  logic [cntWidth-1:0] cnt;
  logic [cntWidth-1:0] cnt_in;
  logic                xfer;
  logic                start_ok;
  logic                is_end;

  assign xfer     = s_valid && s_ready;
  assign cnt_in   = s_data[cntWidth-1:0];
  assign is_end   = (s_data == endMarker);
  // A start landing in the load_done cycle belongs to the finished load.
  assign start_ok = (state == IDLE) && start && !load_done;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; every non-IDLE state waits for a transfer.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_ok) next_state = HDR_LAYER;
        else          next_state = IDLE;
      end
      HDR_LAYER: begin
        if (xfer && is_end) next_state = IDLE;
        else if (xfer)      next_state = HDR_NEURON;
        else                next_state = HDR_LAYER;
      end
      HDR_NEURON: begin
        if (xfer) next_state = HDR_COUNT;
        else      next_state = HDR_NEURON;
      end
      HDR_COUNT: begin
        if (xfer && (cnt_in == CNT_ZERO)) next_state = BIAS;
        else if (xfer)                    next_state = WEIGHTS;
        else                              next_state = HDR_COUNT;
      end
      WEIGHTS: begin
        // The transfer that takes the counter from 1 to 0 is the last weight.
        if (xfer && (cnt == CNT_ONE)) next_state = BIAS;
        else                          next_state = WEIGHTS;
      end
      BIAS: begin
        if (xfer) next_state = HDR_LAYER;
        else      next_state = BIAS;
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state so they track
  // the state register exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready <= 1'b0;
      busy    <= 1'b0;
    end else begin
      s_ready <= (next_state != IDLE);
      busy    <= (next_state != IDLE);
    end
  end

  // One-cycle output pulses, one cycle after the matching transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      weightValid <= 1'b0;
      biasValid   <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      weightValid <= xfer && (state == WEIGHTS);
      biasValid   <= xfer && (state == BIAS);
      load_done   <= xfer && (state == HDR_LAYER) && is_end;
    end
  end

  // Header capture, weight counter and data words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      config_layer_num  <= 32'd0;
      config_neuron_num <= 32'd0;
      cnt               <= CNT_ZERO;
      weightValue       <= 32'd0;
      biasValue         <= 32'd0;
    end else if (xfer) begin
      case (state)
        HDR_LAYER: begin
          if (!is_end) config_layer_num <= s_data;
          else         config_layer_num <= config_layer_num;
        end
        HDR_NEURON: config_neuron_num <= s_data;
        HDR_COUNT:  cnt               <= cnt_in;
        WEIGHTS: begin
          weightValue <= s_data;
          cnt         <= cnt - CNT_ONE;
        end
        BIAS:    biasValue <= s_data;
        default: cnt       <= cnt;
      endcase
    end else begin
      cnt <= cnt;
    end
  end

  // Record counter: cleared by an accepted start, saturating on bias transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      record_cnt <= 16'd0;
    end else if (start_ok) begin
      record_cnt <= 16'd0;
    end else if (xfer && (state == BIAS) && (record_cnt != 16'hFFFF)) begin
      record_cnt <= record_cnt + 16'd1;
    end else begin
      record_cnt <= record_cnt;
    end
  end

endmodule : cfg_loader

// File: tb/tb_cfg_loader.sv
// -----------------------------------------------------------------------------
// tb_cfg_loader
// Directed bench for cfg_loader. Inputs change and outputs are checked on the
// falling clock edge, half a cycle away from the rising active edge.
// -----------------------------------------------------------------------------
module tb_cfg_loader;

  localparam int K_NONE = 0;
  localparam int K_W    = 1;
  localparam int K_B    = 2;
  localparam int K_DONE = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weightValid;
  logic        biasValid;
  logic [31:0] weightValue;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        load_done;
  logic [15:0] record_cnt;

  int checks = 0;
  int fails  = 0;

  cfg_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .weightValid       (weightValid),
    .biasValid         (biasValid),
    .weightValue       (weightValue),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .load_done         (load_done),
    .record_cnt        (record_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word for a single rising edge (caller sits on a falling edge),
  // then check the pulses that transfer must produce one cycle later.
  task automatic send(input string tag, input logic [31:0] w, input int kind);
    s_data  = w;
    s_valid = 1'b1;
    chk({tag, ".s_ready"}, {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    chk({tag, ".weightValid"}, {31'd0, weightValid}, (kind == K_W) ? 32'd1 : 32'd0);
    chk({tag, ".biasValid"},   {31'd0, biasValid},   (kind == K_B) ? 32'd1 : 32'd0);
    chk({tag, ".load_done"},   {31'd0, load_done},   (kind == K_DONE) ? 32'd1 : 32'd0);
    if (kind == K_W) chk({tag, ".weightValue"}, weightValue, w);
    if (kind == K_B) chk({tag, ".biasValue"}, biasValue, w);
  endtask

  // Idle cycles with s_valid low: nothing may pulse.
  task automatic gap(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, ".gap_pulse"}, {29'd0, weightValid, biasValid, load_done}, 32'd0);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    start   = 1'b0;
    s_data  = 32'd0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst.s_ready",    {31'd0, s_ready}, 32'd0);
    chk("rst.busy",       {31'd0, busy}, 32'd0);
    chk("rst.record_cnt", {16'd0, record_cnt}, 32'd0);
    chk("rst.layer",      config_layer_num, 32'd0);
    chk("rst.pulses",     {29'd0, weightValid, biasValid, load_done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // s_valid in IDLE: no transfer, no state change
    s_data  = 32'd5;
    s_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.s_ready", {31'd0, s_ready}, 32'd0);
    chk("idle.busy",    {31'd0, busy}, 32'd0);
    chk("idle.layer",   config_layer_num, 32'd0);
    chk("idle.pulses",  {29'd0, weightValid, biasValid, load_done}, 32'd0);
    s_valid = 1'b0;

    // Record {2,4,3,W0,W1,W2,B} with s_valid held high
    pulse_start();
    chk("start.busy",       {31'd0, busy}, 32'd1);
    chk("start.record_cnt", {16'd0, record_cnt}, 32'd0);
    send("r1.layer",  32'd2, K_NONE);
    send("r1.neuron", 32'd4, K_NONE);
    send("r1.count",  32'd3, K_NONE);
    send("r1.w0", 32'h1111_0000, K_W);
    chk("r1.layer_num",  config_layer_num, 32'd2);
    chk("r1.neuron_num", config_neuron_num, 32'd4);
    send("r1.w1", 32'h1111_0001, K_W);
    send("r1.w2", 32'h1111_0002, K_W);
    send("r1.b",  32'hB1B1_0000, K_B);
    chk("r1.record_cnt", {16'd0, record_cnt}, 32'd1);
    chk("r1.layer_hold", config_layer_num, 32'd2);
    chk("r1.neuron_hold", config_neuron_num, 32'd4);

    // start while busy is ignored: record_cnt must not clear
    pulse_start();
    chk("busy_start.record_cnt", {16'd0, record_cnt}, 32'd1);
    chk("busy_start.busy",       {31'd0, busy}, 32'd1);

    // Record {1,0,0,B}: straight to bias
    send("r2.layer",  32'd1, K_NONE);
    send("r2.neuron", 32'd0, K_NONE);
    send("r2.count",  32'd0, K_NONE);
    send("r2.b",  32'hB2B2_0000, K_B);
    chk("r2.record_cnt", {16'd0, record_cnt}, 32'd2);
    chk("r2.layer_num",  config_layer_num, 32'd1);

    // End marker; a start in the load_done cycle must be ignored
    send("end1", 32'hFFFF_FFFF, K_DONE);
    chk("end1.busy",    {31'd0, busy}, 32'd0);
    chk("end1.s_ready", {31'd0, s_ready}, 32'd0);
    chk("end1.layer_kept", config_layer_num, 32'd1);
    pulse_start();
    chk("done_start.busy",       {31'd0, busy}, 32'd0);
    chk("done_start.load_done",  {31'd0, load_done}, 32'd0);
    chk("done_start.record_cnt", {16'd0, record_cnt}, 32'd2);

    // Two records with random s_valid gaps, then end marker
    pulse_start();
    chk("load2.busy",       {31'd0, busy}, 32'd1);
    chk("load2.record_cnt", {16'd0, record_cnt}, 32'd0);
    send("r3.layer",  32'd7, K_NONE);  gap("r3", $urandom_range(0, 3));
    send("r3.neuron", 32'd9, K_NONE);  gap("r3", $urandom_range(0, 3));
    send("r3.count",  32'd2, K_NONE);  gap("r3", $urandom_range(0, 3));
    send("r3.w0", 32'h3333_0000, K_W); gap("r3", $urandom_range(0, 3));
    send("r3.w1", 32'h3333_0001, K_W); gap("r3", $urandom_range(0, 3));
    chk("r3.layer_num",  config_layer_num, 32'd7);
    chk("r3.neuron_num", config_neuron_num, 32'd9);
    send("r3.b",  32'hB3B3_0000, K_B); gap("r3", $urandom_range(0, 3));
    send("r4.layer",  32'd8, K_NONE);  gap("r4", $urandom_range(0, 3));
    send("r4.neuron", 32'd3, K_NONE);  gap("r4", $urandom_range(0, 3));
    send("r4.count",  32'd1, K_NONE);  gap("r4", $urandom_range(0, 3));
    send("r4.w0", 32'h4444_0000, K_W); gap("r4", $urandom_range(0, 3));
    send("r4.b",  32'hB4B4_0000, K_B); gap("r4", $urandom_range(0, 3));
    send("end2", 32'hFFFF_FFFF, K_DONE);
    chk("end2.busy",       {31'd0, busy}, 32'd0);
    chk("end2.s_ready",    {31'd0, s_ready}, 32'd0);
    chk("end2.record_cnt", {16'd0, record_cnt}, 32'd2);
    gap("end2", 2);

    // Reset after the second weight of an N=5 record
    pulse_start();
    send("r5.layer",  32'd5, K_NONE);
    send("r5.neuron", 32'd6, K_NONE);
    send("r5.count",  32'd5, K_NONE);
    send("r5.w0", 32'h5555_0000, K_W);
    send("r5.w1", 32'h5555_0001, K_W);
    #2 rst = 1'b0;
    #1;
    chk("r5rst.s_ready",     {31'd0, s_ready}, 32'd0);
    chk("r5rst.busy",        {31'd0, busy}, 32'd0);
    chk("r5rst.pulses",      {29'd0, weightValid, biasValid, load_done}, 32'd0);
    chk("r5rst.weightValue", weightValue, 32'd0);
    chk("r5rst.biasValue",   biasValue, 32'd0);
    chk("r5rst.layer",       config_layer_num, 32'd0);
    chk("r5rst.neuron",      config_neuron_num, 32'd0);
    chk("r5rst.record_cnt",  {16'd0, record_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // After release, words without start are not accepted
    s_data  = 32'h5555_0002;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst.s_ready", {31'd0, s_ready}, 32'd0);
      chk("post_rst.pulses",  {29'd0, weightValid, biasValid, load_done}, 32'd0);
    end
    chk("post_rst.busy",  {31'd0, busy}, 32'd0);
    chk("post_rst.layer", config_layer_num, 32'd0);
    s_valid = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_cfg_loader
